// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm scanner.
// N_VARS : number of function variables (v,w,x,y,z; v is the index MSB)
// TT_W   : truth-table width, bit i holds f at minterm index i
// state_e: scanner FSM states
// idx_t / cnt_t / tt_t : index, minterm-count and truth-table types
package minterm_pkg;

  localparam int N_VARS = 5;
  localparam int TT_W   = 1 << N_VARS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [N_VARS-1:0] idx_t;
  // One extra bit so a full table (TT_W minterms) is representable.
  typedef logic [N_VARS:0]   cnt_t;
  typedef logic [TT_W-1:0]   tt_t;

endpackage

// File: rtl/minterm_scanner_last_bit_detect.sv
// Combinational "no set bit above idx" detector.
// Ports:
//   tt_q       : latched truth table
//   idx        : index currently being examined
//   none_above : 1 when tt_q has no 1 at any position strictly above idx
module last_bit_detect
  import minterm_pkg::*;
(
  input  tt_t  tt_q,
  input  idx_t idx,
  output logic none_above
);

  always_comb begin
    none_above = 1'b1;
    for (int i = 0; i < TT_W; i++) begin
      if ((i > int'(idx)) && tt_q[i]) begin
        none_above = 1'b0;
      end
    end
  end

endmodule

// File: rtl/minterm_scanner.sv
// Minterm scanner: walks a latched 5-variable truth table one index per
// clock and emits the index of every 1 as a beat on a valid/ready stream.
// Ports:
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   start, tt       : job request (sampled only in IDLE) and truth table
//   busy            : high while a job is in SCAN or DRAIN
//   m_valid/m_ready : output stream handshake
//   m_index, m_last : beat payload; m_last marks the highest set bit
//   done            : one-cycle pulse when a job completes
//   count           : minterms emitted by the current/last job
//   dbg_state       : current FSM state, for observation
//
// Handshake: a beat transfers on any cycle where m_valid && m_ready at the
// rising edge. While m_valid is high and m_ready is low, m_index, m_last and
// m_valid are held stable and the scan does not advance.
module minterm_scanner
  import minterm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TT_W-1:0]   tt,
  output logic              busy,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_VARS-1:0] m_index,
  output logic              m_last,
  output logic              done,
  output logic [N_VARS:0]   count,
  output logic [1:0]        dbg_state
);

  state_e state_q, state_d;
  tt_t    tt_q, tt_d;
  idx_t   idx_q, idx_d;
  cnt_t   count_q, count_d;
  logic   m_valid_q, m_valid_d;
  idx_t   m_index_q, m_index_d;
  logic   m_last_q, m_last_d;
  logic   done_q, done_d;

  logic   none_above;
  logic   out_free;

  last_bit_detect u_last_bit_detect (
    .tt_q       (tt_q),
    .idx        (idx_q),
    .none_above (none_above)
  );

  // Output register can take a new beat when empty or being consumed now.
  assign out_free = !m_valid_q || m_ready;

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tt_q      <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_index_q <= '0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tt_q      <= tt_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_index_q <= m_index_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    tt_d      = tt_q;
    idx_d     = idx_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    m_index_d = m_index_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          tt_d    = tt;
          idx_d   = '0;
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (out_free) begin
          if (tt_q[idx_q]) begin
            m_valid_d = 1'b1;
            m_index_d = idx_q;
            m_last_d  = none_above;
            count_d   = count_q + cnt_t'(1);
          end else begin
            m_valid_d = 1'b0;
          end
          // Final index: stop here rather than wrap back to 0.
          if (idx_q == idx_t'(TT_W - 1)) begin
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + idx_t'(1);
          end
        end
      end
      DRAIN: begin
        if (out_free) begin
          m_valid_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy      = (state_q != IDLE);
    dbg_state = state_q;
    m_valid   = m_valid_q;
    m_index   = m_index_q;
    m_last    = m_last_q;
    done      = done_q;
    count     = count_q;
  end

endmodule

// File: tb/tb_minterm_scanner.sv
module tb_minterm_scanner;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] tt;
  logic        busy;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_index;
  logic        m_last;
  logic        done;
  logic [5:0]  count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  minterm_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tt        (tt),
    .busy      (busy),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_index   (m_index),
    .m_last    (m_last),
    .done      (done),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: start accepted at the next edge (edge 0); returns at edge 0 + 1.
  task automatic pulse_start(input logic [31:0] t);
    tt    = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b1; tt = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, m_valid, m_index, m_last, done, count, dbg_state} !== 16'd0)
      $display("FAIL reset_in: got busy=%b v=%b idx=%0d last=%b done=%b cnt=%0d st=%0d, want all 0",
               busy, m_valid, m_index, m_last, done, count, dbg_state);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, m_valid, done, count, dbg_state} !== 10'd0)
      $display("FAIL reset_idle: got busy=%b v=%b done=%b cnt=%0d st=%0d, want 0",
               busy, m_valid, done, count, dbg_state);
    else n_pass++;
  endtask

  task automatic test_sparse();
    logic [31:0] tv;
    logic        exp_v;
    logic [4:0]  exp_i;
    int          beats;
    tv = 32'h7F304C3F;
    exp_q = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd10, 5'd11, 5'd14, 5'd20,
              5'd21, 5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30};
    beats = 0;
    m_ready = 1'b1;
    pulse_start(tv);
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk); #1;
      exp_v = 1'b0;
      if (e <= 32) exp_v = tv[e-1];
      n_checks++;
      if (m_valid !== exp_v) $display("FAIL sparse_valid e=%0d: got %b want %b", e, m_valid, exp_v);
      else n_pass++;
      if (m_valid === 1'b1) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sparse_extra e=%0d: got beat %0d want none", e, m_index);
        end else begin
          exp_i = exp_q.pop_front();
          n_checks++;
          if (m_index !== exp_i) $display("FAIL sparse_index e=%0d: got %0d want %0d", e, m_index, exp_i);
          else n_pass++;
          n_checks++;
          if (m_last !== (exp_q.size() == 0))
            $display("FAIL sparse_last idx=%0d: got %b want %b", exp_i, m_last, exp_q.size() == 0);
          else n_pass++;
        end
      end
      n_checks++;
      if (done !== (e == 33)) $display("FAIL sparse_done e=%0d: got %b want %b", e, done, e == 33);
      else n_pass++;
      if (e == 16) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL sparse_busy: got %b want 1", busy);
        else n_pass++;
      end
      if (e == 32) begin
        n_checks++;
        if (dbg_state !== 2'd2) $display("FAIL sparse_drain_state: got %0d want 2", dbg_state);
        else n_pass++;
      end
    end
    n_checks++;
    if (beats != 18 || count !== 6'd18)
      $display("FAIL sparse_count: got beats=%0d count=%0d want 18", beats, count);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL sparse_idle: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_empty();
    int vhigh;
    vhigh = 0;
    m_ready = 1'b1;
    pulse_start(32'h0);
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b0) vhigh++;
      n_checks++;
      if (done !== (e == 33)) $display("FAIL empty_done e=%0d: got %b want %b", e, done, e == 33);
      else n_pass++;
    end
    n_checks++;
    if (vhigh != 0) $display("FAIL empty_valid: got %0d valid cycles want 0", vhigh);
    else n_pass++;
    n_checks++;
    if (count !== 6'd0 || busy !== 1'b0)
      $display("FAIL empty_end: got count=%0d busy=%b want 0/0", count, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    pulse_start(32'hFFFFFFFF);
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== (e <= 32)) $display("FAIL full_valid e=%0d: got %b want %b", e, m_valid, e <= 32);
      else n_pass++;
      if (e <= 32) begin
        n_checks++;
        if (m_index !== 5'(e - 1) || m_last !== (e == 32))
          $display("FAIL full_beat e=%0d: got idx=%0d last=%b want idx=%0d last=%b",
                   e, m_index, m_last, e - 1, e == 32);
        else n_pass++;
      end
      n_checks++;
      if (done !== (e == 33)) $display("FAIL full_done e=%0d: got %b want %b", e, done, e == 33);
      else n_pass++;
    end
    n_checks++;
    if (count !== 6'd32) $display("FAIL full_count: got %0d want 32", count);
    else n_pass++;
  endtask

  task automatic test_stall();
    m_ready = 1'b0;
    pulse_start(32'h00008001);
    @(posedge clk); #1;
    n_checks++;
    if (m_valid !== 1'b1 || m_index !== 5'd0 || m_last !== 1'b0 || count !== 6'd1)
      $display("FAIL stall_first: got v=%b idx=%0d last=%b cnt=%0d want 1/0/0/1",
               m_valid, m_index, m_last, count);
    else n_pass++;
    for (int s = 2; s <= 6; s++) begin
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_index !== 5'd0 || m_last !== 1'b0 || count !== 6'd1 ||
          dut.idx_q !== 5'd1)
        $display("FAIL stall_hold e=%0d: got v=%b idx=%0d last=%b cnt=%0d scan=%0d want 1/0/0/1/1",
                 s, m_valid, m_index, m_last, count, dut.idx_q);
      else n_pass++;
    end
    m_ready = 1'b1;
    for (int e = 7; e <= 40; e++) begin
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== (e == 21)) $display("FAIL stall_valid e=%0d: got %b want %b", e, m_valid, e == 21);
      else n_pass++;
      if (e == 21) begin
        n_checks++;
        if (m_index !== 5'd15 || m_last !== 1'b1)
          $display("FAIL stall_beat15: got idx=%0d last=%b want 15/1", m_index, m_last);
        else n_pass++;
      end
      n_checks++;
      if (done !== (e == 38)) $display("FAIL stall_done e=%0d: got %b want %b", e, done, e == 38);
      else n_pass++;
    end
    n_checks++;
    if (count !== 6'd2) $display("FAIL stall_count: got %0d want 2", count);
    else n_pass++;
  endtask

  task automatic test_restart_and_reset();
    int bad;
    m_ready = 1'b1;
    pulse_start(32'h00000011);
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== (e == 1 || e == 5))
        $display("FAIL restart_valid e=%0d: got %b want %b", e, m_valid, e == 1 || e == 5);
      else n_pass++;
      n_checks++;
      if (done !== (e == 33)) $display("FAIL restart_done e=%0d: got %b want %b", e, done, e == 33);
      else n_pass++;
      // Re-pulse mid-job, then again in the cycle that produces done.
      if (e == 2)  begin tt = 32'hFFFFFFFF; start = 1'b1; end
      if (e == 3)  start = 1'b0;
      if (e == 32) start = 1'b1;
      if (e == 33) start = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b0 || count !== 6'd2)
      $display("FAIL restart_end: got busy=%b count=%0d want 0/2", busy, count);
    else n_pass++;

    pulse_start(32'hFFFFFFFF);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || count !== 6'd0 || done !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL midreset: got v=%b busy=%b cnt=%0d done=%b st=%0d want all 0",
               m_valid, busy, count, done, dbg_state);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL midreset_quiet: got %0d active cycles want 0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_empty();
    test_back_to_back();
    test_stall();
    test_restart_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
